sin_channel_scheduler: RTL and testbench
========================================

// Module: sin_channel_scheduler
// PURPOSE
//  Time-multiplexes a single synchronous sine-table ROM between NUM_CH independent tone channels.
//  - Each channel has its own phase accumulator, frequency tuning word (FTW) and phase offset.
//  - A round-robin slot counter issues one ROM read per channel per frame of NUM_CH cycles.
//  - Returned samples are tagged with their channel number.
//  - Sits between the register/config interface and the sine-table ROM; feeds the DAC mux.
// PARAMETERS
//  NUM_CH   4    number of channels (>=2); CH_W = $clog2(NUM_CH)
//  ADDR_W   8    ROM address width for a full-wave table; table length = 2**ADDR_W
//  ACC_W    16   phase accumulator / FTW width (ACC_W > ADDR_W)
//  DATA_W   12   sample width, unsigned offset-binary (mid-scale = 2**(DATA_W-1))
// PORTS
//  clk            in   1       clock
//  reset          in   1       asynchronous, active-high reset
//  ch_enable      in   NUM_CH  per-channel run enable
//  cfg_we         in   1       config write strobe (single cycle)
//  cfg_ch         in   CH_W    channel addressed by cfg_we
//  cfg_ftw        in   ACC_W   FTW written to shadow[cfg_ch]
//  cfg_phase      in   ADDR_W  phase offset written to shadow[cfg_ch]
//  rom_en         out  1       ROM read enable
//  rom_addr       out  RA_W    ROM address; RA_W = ADDR_W, or ADDR_W-2 with SIN_SCHED_QUARTER_EN
//  rom_data       in   DATA_W  ROM data, valid the cycle after rom_en
//  sample_valid   out  1       sample_data/sample_ch valid (single-cycle pulse)
//  sample_ch      out  CH_W    channel of the current sample
//  sample_data    out  DATA_W  output sample
//  frame_strobe   out  1       pulses in the cycle that slot 0 is issued
// BEHAVIOUR
//  Reset (async)
//  - Clears slot counter, all accumulators, active and shadow FTW/phase, and the pipeline.
//  - All outputs go to 0; the first slot-0 issue occurs in the first cycle after reset deasserts.
//  - Reset mid-frame discards all in-flight reads; no sample_valid follows.
//  Slot counter
//  - slot cycles 0..NUM_CH-1 and wraps to 0, one slot per clk, never stalls.
//  Frame boundary (slot==0)
//  - Copies all shadow FTW/phase values to the active registers before issuing.
//  - A cfg_we in the same cycle as slot 0 lands in shadow and applies at the next frame.
//  - Repeated writes to one channel within a frame: last write wins.
//  Issue, in the cycle of slot s
//  - Enabled channel s:
//    - rom_en=1 next cycle;
//    - rom_addr = acc[s][ACC_W-1 -: ADDR_W] + phase[s], taken mod 2**ADDR_W (pre-increment value);
//    - acc[s] <= acc[s] + ftw[s], wrapping mod 2**ACC_W.
//  - Disabled channel s:
//    - rom_en=0 and acc[s] <= 0;
//    - no sample is produced for that slot.
//    - On re-enable, the first address is therefore phase[s].
//  Latency
//  - rom_en/rom_addr are registered: asserted 1 cycle after the slot.
//  - sample_valid/sample_ch/sample_data are registered 1 cycle after rom_data is valid.
//  - Total: 3 cycles from slot to sample_valid.
//  - Output order equals issue order; one sample max per cycle.
//  Output hold
//  - sample_data and sample_ch hold their last value while sample_valid=0.
//  frame_strobe
//  - Registered, aligned with rom_en of slot 0.
//  - Asserts even when channel 0 is disabled.
// CONFIGURATION
//  SIN_SCHED_QUARTER_EN defined: the ROM holds a quarter-wave table (2**(ADDR_W-2) entries).
//  - Full address A: q = A[ADDR_W-1:ADDR_W-2], i = A[ADDR_W-3:0].
//  - rom_addr = q[0] ? ~i : i.
//  - q[1] is pipelined alongside the read; sample_data = q[1] ? ~rom_data : rom_data.
//  - Latency is unchanged.
//  SIN_SCHED_QUARTER_EN undefined: rom_addr = A, and sample_data = rom_data.
// TESTING (NUM_CH=4, ADDR_W=8, ACC_W=16, DATA_W=12; ROM model returns data = addr)
//  1. Single channel
//     - ch_enable=4'b0001, ftw[0]=0x0100, phase 0.
//     - Response: ch0 samples 0,1,2,... one every 4 cycles; first sample_valid 3 cycles after reset release.
//     - Wraps 255 -> 0; frame_strobe every 4 cycles.
//  2. Four channels
//     - All enabled; ftw=0x0100,0x0200,0x0080,0x0000; phase 0,0,0,0x40.
//     - Response: sample_ch sequence 0,1,2,3 repeating.
//     - Per-channel data: ch0 0,1,2; ch1 0,2,4; ch2 0,0,1,1; ch3 constant 0x40.
//  3. Shadowed config
//     - cfg_we to ch1 (ftw=0x0400) in the slot-2 cycle.
//     - Response: ch1 step changes only from the next frame; earlier ch1 samples keep the old step.
//  4. Enable/disable
//     - Disable ch2 for one frame, then re-enable.
//     - Response: no ch2 sample that frame; the first ch2 sample after re-enable equals phase[2].
//  5. Reset mid-operation
//     - Assert reset 1 cycle after a rom_en.
//     - Response: all outputs 0 immediately; no sample_valid; restart from acc=0.
//  6. Quarter-wave (SIN_SCHED_QUARTER_EN)
//     - A = 0x05 -> rom_addr 0x05, data 0x005.
//     - A = 0x45 -> rom_addr 0x3A, data 0x03A.
//     - A = 0x85 -> rom_addr 0x05, data 0xFFA.
//     - A = 0xC5 -> rom_addr 0x3A, data 0xFC5.

Source files
------------

// File: rtl/sin_channel_scheduler.sv
// sin_channel_scheduler
//
// Shares one synchronous sine-table ROM between NUM_CH tone channels. A free-running
// round-robin slot counter gives each channel one ROM read per frame of NUM_CH cycles. Each
// channel has a phase accumulator plus double-buffered FTW / phase-offset registers. Config
// writes land in the shadow copy, which is loaded into the active copy at every frame start.
//
// Optional build macro: SIN_SCHED_QUARTER_EN
//   Selects a quarter-wave ROM (2**(ADDR_W-2) entries). The address is mirrored in odd
//   quadrants and the returned data is inverted in the second half-wave.
//   The latency is the same as in the full-wave build.
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high reset
//   ch_enable     per-channel run enable; a disabled channel clears its accumulator
//   cfg_we        single-cycle config write strobe
//   cfg_ch        channel addressed by cfg_we
//   cfg_ftw       frequency tuning word for the shadow register
//   cfg_phase     phase offset for the shadow register
//   rom_en        ROM read enable (one cycle after the slot)
//   rom_addr      ROM address (ADDR_W bits, or ADDR_W-2 in quarter-wave builds)
//   rom_data      ROM read data, valid the cycle after rom_en
//   sample_valid  single-cycle pulse qualifying sample_ch / sample_data
//   sample_ch     channel tag of the current sample (held between samples)
//   sample_data   unsigned offset-binary sample (held between samples)
//   frame_strobe  pulses alongside the rom_en slot of slot 0, even if channel 0 is disabled
module sin_channel_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned DATA_W = 12,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ADDR_W-1:0] cfg_phase,
  output logic              rom_en,
`ifdef SIN_SCHED_QUARTER_EN
  output logic [ADDR_W-3:0] rom_addr,
`else
  output logic [ADDR_W-1:0] rom_addr,
`endif
  input  logic [DATA_W-1:0] rom_data,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic              frame_strobe
);

`ifdef SIN_SCHED_QUARTER_EN
  localparam int unsigned RA_W = ADDR_W - 2;
`else
  localparam int unsigned RA_W = ADDR_W;
`endif
  localparam logic [CH_W-1:0] LastSlot = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]   slot_q;
  logic [ACC_W-1:0]  acc_q       [NUM_CH];
  logic [ACC_W-1:0]  ftw_act_q   [NUM_CH];
  logic [ACC_W-1:0]  ftw_shd_q   [NUM_CH];
  logic [ADDR_W-1:0] phase_act_q [NUM_CH];
  logic [ADDR_W-1:0] phase_shd_q [NUM_CH];

  logic              frame_start;
  logic [ACC_W-1:0]  cur_acc;
  logic [ACC_W-1:0]  cur_ftw;
  logic [ADDR_W-1:0] cur_phase;
  logic [ADDR_W-1:0] full_addr;
  logic [RA_W-1:0]   mapped_addr;
  logic              mapped_neg;

  // Issue stage / read stage / output stage registers
  logic              rom_en_q, frame_strobe_q, iss_neg_q;
  logic [RA_W-1:0]   rom_addr_q;
  logic [CH_W-1:0]   iss_ch_q, rd_ch_q, sample_ch_q;
  logic              rd_valid_q, rd_neg_q, sample_valid_q;
  logic [DATA_W-1:0] sample_data_q;

  assign frame_start = (slot_q == '0);

  always_comb begin
    cur_acc   = acc_q[slot_q];
    // At the frame boundary the shadow values are what get copied into the active set this
    // cycle, so slot 0 must already issue with them.
    cur_ftw   = frame_start ? ftw_shd_q[slot_q]   : ftw_act_q[slot_q];
    cur_phase = frame_start ? phase_shd_q[slot_q] : phase_act_q[slot_q];
    full_addr = cur_acc[ACC_W-1 -: ADDR_W] + cur_phase;
`ifdef SIN_SCHED_QUARTER_EN
    // Odd quadrants run the table backwards; the upper half-wave is the inverted lower one.
    mapped_addr = full_addr[ADDR_W-2] ? ~full_addr[ADDR_W-3:0] : full_addr[ADDR_W-3:0];
    mapped_neg  = full_addr[ADDR_W-1];
`else
    mapped_addr = full_addr;
    mapped_neg  = 1'b0;
`endif
  end

  // Slot counter, per-channel state and config registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]       <= '0;
        ftw_act_q[i]   <= '0;
        ftw_shd_q[i]   <= '0;
        phase_act_q[i] <= '0;
        phase_shd_q[i] <= '0;
      end
    end else begin
      slot_q <= (slot_q == LastSlot) ? '0 : slot_q + 1'b1;
      if (frame_start) begin
        ftw_act_q   <= ftw_shd_q;
        phase_act_q <= phase_shd_q;
      end
      if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
        ftw_shd_q[cfg_ch]   <= cfg_ftw;
        phase_shd_q[cfg_ch] <= cfg_phase;
      end
      // A disabled channel restarts from its phase offset when re-enabled
      acc_q[slot_q] <= ch_enable[slot_q] ? cur_acc + cur_ftw : '0;
    end
  end

  // Three-stage read pipeline: issue, ROM access, output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_en_q       <= 1'b0;
      rom_addr_q     <= '0;
      frame_strobe_q <= 1'b0;
      iss_ch_q       <= '0;
      iss_neg_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_ch_q        <= '0;
      rd_neg_q       <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
    end else begin
      rom_en_q       <= ch_enable[slot_q];
      frame_strobe_q <= frame_start;
      if (ch_enable[slot_q]) begin
        rom_addr_q <= mapped_addr;
        iss_ch_q   <= slot_q;
        iss_neg_q  <= mapped_neg;
      end
      rd_valid_q     <= rom_en_q;
      rd_ch_q        <= iss_ch_q;
      rd_neg_q       <= iss_neg_q;
      sample_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        sample_ch_q   <= rd_ch_q;
        sample_data_q <= rd_neg_q ? ~rom_data : rom_data;
      end
    end
  end

  assign rom_en       = rom_en_q;
  assign rom_addr     = rom_addr_q;
  assign frame_strobe = frame_strobe_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;

endmodule

// File: tb/tb_sin_channel_scheduler.sv
// Directed bench for sin_channel_scheduler (NUM_CH=4, ADDR_W=8, ACC_W=16, DATA_W=12).
// The ROM model returns data equal to the address it was given.
// Cycle numbering: cycle 0 is the first cycle after reset release, and it is slot 0.
`timescale 1ns/1ps
module tb_sin_channel_scheduler;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned DATA_W = 12;
`ifdef SIN_SCHED_QUARTER_EN
  localparam int unsigned RA_W = ADDR_W - 2;
`else
  localparam int unsigned RA_W = ADDR_W;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        ch_enable = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [15:0]       cfg_ftw = '0;
  logic [7:0]        cfg_phase = '0;
  logic              rom_en;
  logic [RA_W-1:0]   rom_addr;
  logic [11:0]       rom_data;
  logic              sample_valid;
  logic [1:0]        sample_ch;
  logic [11:0]       sample_data;
  logic              frame_strobe;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  sin_channel_scheduler #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .ch_enable(ch_enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data = address
  always_ff @(posedge clk) if (rom_en) rom_data <= DATA_W'(rom_addr);

  // Expected ROM address for full phase address a
  function automatic logic [RA_W-1:0] exp_addr(input logic [7:0] a);
`ifdef SIN_SCHED_QUARTER_EN
    logic [5:0] i;
    i = a[5:0];
    return a[6] ? ~i : i;
`else
    return a;
`endif
  endfunction

  // Expected sample for full phase address a, given the data = address ROM
  function automatic logic [11:0] exp_data(input logic [7:0] a);
    logic [11:0] d;
    d = 12'(exp_addr(a));
`ifdef SIN_SCHED_QUARTER_EN
    if (a[7]) d = ~d;
`endif
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] ftw, input logic [7:0] ph);
    cfg_we = 1'b1; cfg_ch = ch; cfg_ftw = ftw; cfg_phase = ph;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] outs;
    ch_enable = 4'b0001;
    #1 reset = 1'b1;
    #2;
    outs = {rom_en, 6'(rom_addr), sample_valid, sample_ch, sample_data, frame_strobe};
    n_checks++; if (outs !== '0) $display("FAIL reset_outs got %h exp 0", outs); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; cyc = 0;
    n_checks++; if ({rom_en, frame_strobe, sample_valid} !== 3'b000)
      $display("FAIL reset_c0 got %b exp 000", {rom_en, frame_strobe, sample_valid});
    else n_pass++;
    tick();
    n_checks++; if ({rom_en, frame_strobe} !== 2'b11)
      $display("FAIL reset_c1 got %b exp 11", {rom_en, frame_strobe}); else n_pass++;
    n_checks++; if (rom_addr !== exp_addr(8'h00))
      $display("FAIL reset_addr got %h exp %h", rom_addr, exp_addr(8'h00)); else n_pass++;
    tick();
    n_checks++; if (sample_valid !== 1'b0)
      $display("FAIL reset_c2 got %b exp 0", sample_valid); else n_pass++;
    tick();
    n_checks++; if ({sample_valid, sample_ch, sample_data} !== {1'b1, 2'd0, exp_data(8'h00)})
      $display("FAIL reset_first_sample got %b/%0d/%h exp 1/0/%h",
               sample_valid, sample_ch, sample_data, exp_data(8'h00));
    else n_pass++;
    tick();
    n_checks++; if (sample_valid !== 1'b0)
      $display("FAIL reset_c4 got %b exp 0", sample_valid); else n_pass++;
  endtask

  task automatic test_single();
    logic exp_v;
    logic [7:0] a;
    ch_enable = '0;
    do_reset();
    cfg_write(2'd0, 16'h0100, 8'h00);
    // ch0 runs from frame 1 (cycle 4); its samples appear at cycles 7, 11, ...
    while (cyc < 1045) begin
      if (cyc == 4) ch_enable = 4'b0001;
      n_checks++; if (frame_strobe !== (cyc % 4 == 1))
        $display("FAIL single_strobe cyc=%0d got %b", cyc, frame_strobe); else n_pass++;
      n_checks++; if (rom_en !== (cyc >= 5 && cyc % 4 == 1))
        $display("FAIL single_rom_en cyc=%0d got %b", cyc, rom_en); else n_pass++;
      exp_v = (cyc >= 7) && ((cyc - 7) % 4 == 0);
      n_checks++; if (sample_valid !== exp_v)
        $display("FAIL single_valid cyc=%0d got %b exp %b", cyc, sample_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        a = 8'((cyc - 7) / 4);
        n_checks++; if ({sample_ch, sample_data} !== {2'd0, exp_data(a)})
          $display("FAIL single_data cyc=%0d got %0d/%h exp 0/%h",
                   cyc, sample_ch, sample_data, exp_data(a));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_four();
    int t, n, c;
    logic [7:0] a;
    ch_enable = '0;
    do_reset();
    cfg_write(2'd0, 16'h0100, 8'h00);
    cfg_write(2'd1, 16'h0200, 8'h00);
    cfg_write(2'd2, 16'h0080, 8'h00);
    cfg_write(2'd3, 16'h0000, 8'h40);
    ch_enable = 4'hF;
    while (cyc < 31) begin
      n_checks++; if (sample_valid !== (cyc >= 7))
        $display("FAIL four_valid cyc=%0d got %b", cyc, sample_valid); else n_pass++;
      if (cyc >= 7) begin
        t = cyc - 7; n = t / 4; c = t % 4;
        case (c)
          0: a = 8'(n);
          1: a = 8'(2 * n);
          2: a = 8'(n / 2);
          default: a = 8'h40;
        endcase
        n_checks++; if ({sample_ch, sample_data} !== {2'(c), exp_data(a)})
          $display("FAIL four_data cyc=%0d got %0d/%h exp %0d/%h",
                   cyc, sample_ch, sample_data, c, exp_data(a));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_shadow();
    logic exp_v;
    int n;
    logic [7:0] a;
    ch_enable = '0;
    do_reset();
    cfg_write(2'd1, 16'h0100, 8'h00);
    // Frame n starts at cycle 4+4n; ch1 issues at 5+4n and its sample shows at 8+4n.
    // Two writes in frame 2 (slot 1 then slot 2): the later one must win, from frame 3.
    while (cyc < 36) begin
      if (cyc == 4) ch_enable = 4'b0010;
      cfg_we = (cyc == 13 || cyc == 14);
      cfg_ch = 2'd1;
      cfg_ftw = (cyc == 13) ? 16'h0700 : 16'h0400;
      cfg_phase = 8'h00;
      exp_v = (cyc >= 8) && ((cyc - 8) % 4 == 0);
      n_checks++; if (sample_valid !== exp_v)
        $display("FAIL shadow_valid cyc=%0d got %b exp %b", cyc, sample_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        n = (cyc - 8) / 4;
        a = (n <= 3) ? 8'(n) : 8'(3 + 4 * (n - 3));
        n_checks++; if ({sample_ch, sample_data} !== {2'd1, exp_data(a)})
          $display("FAIL shadow_data cyc=%0d got %0d/%h exp 1/%h",
                   cyc, sample_ch, sample_data, exp_data(a));
        else n_pass++;
      end
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_enable();
    logic exp_v;
    int n;
    logic [7:0] a;
    ch_enable = '0;
    do_reset();
    cfg_write(2'd2, 16'h0100, 8'h30);
    // ch2 issues at 6+4n; disabled for frame 3 (issue cycle 18)
    while (cyc < 34) begin
      if (cyc == 4 || cyc == 20) ch_enable = 4'b0100;
      if (cyc == 16) ch_enable = 4'b0000;
      n_checks++; if (rom_en !== (cyc >= 7 && (cyc - 7) % 4 == 0 && cyc != 19))
        $display("FAIL enable_rom_en cyc=%0d got %b", cyc, rom_en); else n_pass++;
      exp_v = (cyc >= 9) && ((cyc - 9) % 4 == 0) && (cyc != 21);
      n_checks++; if (sample_valid !== exp_v)
        $display("FAIL enable_valid cyc=%0d got %b exp %b", cyc, sample_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        n = (cyc - 9) / 4;
        a = (n < 3) ? 8'(8'h30 + n) : 8'(8'h30 + n - 4);
        n_checks++; if ({sample_ch, sample_data} !== {2'd2, exp_data(a)})
          $display("FAIL enable_data cyc=%0d got %0d/%h exp 2/%h",
                   cyc, sample_ch, sample_data, exp_data(a));
        else n_pass++;
      end
      if (cyc == 21) begin
        n_checks++; if ({sample_ch, sample_data} !== {2'd2, exp_data(8'h32)})
          $display("FAIL enable_hold got %0d/%h exp 2/%h",
                   sample_ch, sample_data, exp_data(8'h32));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] outs;
    logic exp_v;
    logic [7:0] a;
    ch_enable = 4'b0010;
    do_reset();
    cfg_write(2'd1, 16'h0100, 8'h11);
    while (cyc < 10) tick();
    n_checks++; if ({rom_en, rom_addr} !== {1'b1, exp_addr(8'h12)})
      $display("FAIL mid_pre_rom got %b/%h exp 1/%h", rom_en, rom_addr, exp_addr(8'h12));
    else n_pass++;
    tick();
    n_checks++; if ({sample_valid, sample_ch, sample_data} !== {1'b0, 2'd1, exp_data(8'h11)})
      $display("FAIL mid_pre_hold got %b/%0d/%h exp 0/1/%h",
               sample_valid, sample_ch, sample_data, exp_data(8'h11));
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    outs = {rom_en, 6'(rom_addr), sample_valid, sample_ch, sample_data, frame_strobe};
    n_checks++; if (outs !== '0) $display("FAIL mid_outs got %h exp 0", outs); else n_pass++;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_checks++; if (sample_valid !== 1'b0)
        $display("FAIL mid_in_reset_valid got %b exp 0", sample_valid); else n_pass++;
    end
    reset = 1'b0;
    cyc = 0;
    // Restart: frame 0 runs with cleared config, the write at cycle 0 applies from frame 1
    while (cyc < 13) begin
      cfg_we = (cyc == 0);
      cfg_ch = 2'd1; cfg_ftw = 16'h0100; cfg_phase = 8'h00;
      n_checks++; if (rom_en !== (cyc >= 2 && cyc % 4 == 2))
        $display("FAIL mid_rom_en cyc=%0d got %b", cyc, rom_en); else n_pass++;
      exp_v = (cyc >= 4) && (cyc % 4 == 0);
      n_checks++; if (sample_valid !== exp_v)
        $display("FAIL mid_valid cyc=%0d got %b exp %b", cyc, sample_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        a = (cyc == 12) ? 8'h01 : 8'h00;
        n_checks++; if ({sample_ch, sample_data} !== {2'd1, exp_data(a)})
          $display("FAIL mid_data cyc=%0d got %0d/%h exp 1/%h",
                   cyc, sample_ch, sample_data, exp_data(a));
        else n_pass++;
      end
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_phase_step();
    int n;
    logic [7:0] a;
    ch_enable = '0;
    do_reset();
    cfg_write(2'd0, 16'h4000, 8'h05);
    while (cyc < 4) tick();
    ch_enable = 4'b0001;
    // Full addresses 0x05, 0x45, 0x85, 0xC5 sweep all four quadrants
    while (cyc < 20) begin
      if (cyc >= 5 && cyc % 4 == 1) begin
        n = (cyc - 5) / 4;
        a = 8'(5 + 64 * n);
        n_checks++; if ({rom_en, rom_addr} !== {1'b1, exp_addr(a)})
          $display("FAIL quad_addr A=%h got %b/%h exp 1/%h", a, rom_en, rom_addr, exp_addr(a));
        else n_pass++;
      end
      if (cyc >= 7 && cyc % 4 == 3) begin
        n = (cyc - 7) / 4;
        a = 8'(5 + 64 * n);
        n_checks++; if ({sample_valid, sample_data} !== {1'b1, exp_data(a)})
          $display("FAIL quad_data A=%h got %b/%h exp 1/%h",
                   a, sample_valid, sample_data, exp_data(a));
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_shadow();
    test_enable();
    test_reset_mid();
    test_phase_step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
